// File: rtl/time_pkg.sv
// Shared widths, field limits and Gregorian calendar helpers for the
// real-time clock and its consumers.
package time_pkg;

    localparam int YEAR_W  = 16;
    localparam int MONTH_W = 6;
    localparam int FIELD_W = 11;

    localparam logic [FIELD_W-1:0] SEC_MAX   = 11'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX   = 11'd59;
    localparam logic [FIELD_W-1:0] HOUR_MAX  = 11'd23;
    localparam logic [FIELD_W-1:0] WEEK_MAX  = 11'd7;
    localparam logic [YEAR_W-1:0]  YEAR_MAX  = 16'd9999;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 6'd12;

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic div4, div100, div400;
        div4   = (y % 16'd4)   == 16'd0;
        div100 = (y % 16'd100) == 16'd0;
        div400 = (y % 16'd400) == 16'd0;
        return (div4 && !div100) || div400;
    endfunction

    function automatic logic [FIELD_W-1:0] days_in_month(
        input logic [MONTH_W-1:0] m,
        input logic [YEAR_W-1:0]  y
    );
        logic [FIELD_W-1:0] len;
        case (m)
            6'd2:                    len = is_leap(y) ? 11'd29 : 11'd28;
            6'd4, 6'd6, 6'd9, 6'd11: len = 11'd30;
            default:                 len = 11'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/time_keeper_tick_divider.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles.
// The count freezes while en is low so a paused second resumes where it stopped.
module tick_divider #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] TERM = 32'(CLK_HZ - 1);

    logic [31:0] count;

    assign tick = en && !clr && (count == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? 32'd0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Real-time clock/calendar: 1 Hz advance through a full Gregorian carry chain,
// with a sanitising bulk load from the settings logic.
module time_keeper
    import time_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int RST_YEAR = 2000,
    parameter int RST_WEEK = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 load,
    input  logic [YEAR_W-1:0]    load_year,
    input  logic [MONTH_W-1:0]   load_month,
    input  logic [FIELD_W-1:0]   load_day,
    input  logic [FIELD_W-1:0]   load_hour,
    input  logic [FIELD_W-1:0]   load_minute,
    input  logic [FIELD_W-1:0]   load_second,
    input  logic [FIELD_W-1:0]   load_week,
    output logic [YEAR_W-1:0]    year,
    output logic [MONTH_W-1:0]   month,
    output logic [FIELD_W-1:0]   day,
    output logic [FIELD_W-1:0]   hour,
    output logic [FIELD_W-1:0]   minute,
    output logic [FIELD_W-1:0]   second,
    output logic [FIELD_W-1:0]   week,
    output logic                 sec_tick
);

    logic tick;

    tick_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (load),
        .tick (tick)
    );

    // Carry chain: each field rolls only when every faster field is at its limit.
    logic               c_min, c_hour, c_day, c_month, c_year;
    logic [FIELD_W-1:0] dim_cur;

    assign dim_cur = days_in_month(month, year);
    assign c_min   = (second == SEC_MAX);
    assign c_hour  = c_min   && (minute == MIN_MAX);
    assign c_day   = c_hour  && (hour == HOUR_MAX);
    assign c_month = c_day   && (day == dim_cur);
    assign c_year  = c_month && (month == MONTH_MAX);

    logic [YEAR_W-1:0]  nxt_year;
    logic [MONTH_W-1:0] nxt_month;
    logic [FIELD_W-1:0] nxt_day, nxt_hour, nxt_minute, nxt_second, nxt_week;

    always_comb begin
        nxt_year   = year;
        nxt_month  = month;
        nxt_day    = day;
        nxt_hour   = hour;
        nxt_minute = minute;
        nxt_week   = week;
        nxt_second = c_min ? '0 : second + FIELD_W'(1);
        if (c_min)   nxt_minute = (minute == MIN_MAX) ? '0 : minute + FIELD_W'(1);
        if (c_hour)  nxt_hour   = (hour == HOUR_MAX) ? '0 : hour + FIELD_W'(1);
        if (c_day) begin
            nxt_day  = (day == dim_cur) ? FIELD_W'(1) : day + FIELD_W'(1);
            nxt_week = (week == WEEK_MAX) ? FIELD_W'(1) : week + FIELD_W'(1);
        end
        if (c_month) nxt_month = (month == MONTH_MAX) ? MONTH_W'(1) : month + MONTH_W'(1);
        if (c_year)  nxt_year  = (year == YEAR_MAX) ? YEAR_W'(1) : year + YEAR_W'(1);
    end

    // Load sanitising: day clamp depends on the already-clamped month and year.
    logic [YEAR_W-1:0]  s_year;
    logic [MONTH_W-1:0] s_month;
    logic [FIELD_W-1:0] s_day, s_hour, s_minute, s_second, s_week, s_dim;

    always_comb begin
        s_month = load_month;
        if (load_month == '0)            s_month = MONTH_W'(1);
        else if (load_month > MONTH_MAX) s_month = MONTH_MAX;
        s_year = load_year;
        if (load_year == '0)             s_year = YEAR_W'(1);
        else if (load_year > YEAR_MAX)   s_year = YEAR_MAX;
        s_dim = days_in_month(s_month, s_year);
        s_day = load_day;
        if (load_day == '0)              s_day = FIELD_W'(1);
        else if (load_day > s_dim)       s_day = s_dim;
        s_hour   = (load_hour > HOUR_MAX)  ? HOUR_MAX : load_hour;
        s_minute = (load_minute > MIN_MAX) ? MIN_MAX  : load_minute;
        s_second = (load_second > SEC_MAX) ? SEC_MAX  : load_second;
        s_week   = (load_week == '0 || load_week > WEEK_MAX) ? FIELD_W'(1) : load_week;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            year     <= YEAR_W'(RST_YEAR);
            month    <= MONTH_W'(1);
            day      <= FIELD_W'(1);
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            week     <= FIELD_W'(RST_WEEK);
            sec_tick <= 1'b0;
        end else if (load) begin
            year     <= s_year;
            month    <= s_month;
            day      <= s_day;
            hour     <= s_hour;
            minute   <= s_minute;
            second   <= s_second;
            week     <= s_week;
            sec_tick <= 1'b0;
        end else if (tick) begin
            year     <= nxt_year;
            month    <= nxt_month;
            day      <= nxt_day;
            hour     <= nxt_hour;
            minute   <= nxt_minute;
            second   <= nxt_second;
            week     <= nxt_week;
            sec_tick <= 1'b1;
        end else begin
            sec_tick <= 1'b0;
        end
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Real-time clock/calendar counter.
- Produces the hour/minute/second, day/month/year and weekday values consumed by the digit-select display stage.
- Sits directly upstream of that stage. Its output widths and encodings match what the display stage decodes.
- Divides the system clock to a 1 Hz tick, advances a full Gregorian calendar, and accepts a bulk load from the settings logic.

Parameters:
- CLK_HZ, 50_000_000, system clock cycles per second; tick period. Minimum 2.
- RST_YEAR, 2000, year loaded on reset (must be 1..9999).
- RST_WEEK, 6, weekday loaded on reset (must match RST_YEAR-01-01; 2000-01-01 is Saturday = 6).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = time advances; 0 = divider and all counters frozen.
- load  in  1  one-cycle strobe; writes all load_* fields.
- load_year  in  16  1..9999.
- load_month  in  6  1..12.
- load_day  in  11  1..31.
- load_hour  in  11  0..23.
- load_minute  in  11  0..59.
- load_second  in  11  0..59.
- load_week  in  11  1..7.
- year  out  16  current year, binary.
- month  out  6  1..12.
- day  out  11  1..31.
- hour  out  11  0..23.
- minute  out  11  0..59.
- second  out  11  0..59.
- week  out  11  1=Mon .. 7=Sun.
- sec_tick  out  1  one-cycle pulse in the cycle the time fields advance.

Behaviour:
- Reset (rst=1 at a clk edge):
  - year=RST_YEAR, month=1, day=1, hour=minute=second=0, week=RST_WEEK.
  - Divider count=0, sec_tick=0.
  - Reset overrides load and run, including mid-rollover.
- Divider:
  - 32-bit count increments each cycle while run=1 and load=0.
  - At count==CLK_HZ-1, count returns to 0 and the internal tick fires.
  - sec_tick is registered: high in the same cycle the registered time fields show the new value, so consumers sample coherent values.
  - First second after reset completes exactly CLK_HZ cycles later.
- Carry chain (all fields evaluated in one cycle on tick, registered together):
  - second 59->0 carries to minute.
  - minute 59->0 carries to hour.
  - hour 23->0 carries to day and week.
  - week 7->1, else +1.
  - day==days_in_month(month, year) -> day=1, carry to month.
  - month 12->1, carry to year.
  - year 9999->1 (wrap).
- Leap rule: leap = (y%4==0 && y%100!=0) || y%400==0.
  - Feb length 29 if leap, else 28.
  - Apr/Jun/Sep/Nov length 30; all others 31.
- Load:
  - load=1 writes all fields at the next edge, resets divider count to 0, and holds sec_tick=0 that cycle.
  - Load wins over a simultaneous tick; that tick is discarded.
  - Load is honoured when run=0.
- Load sanitising, applied in the load cycle with no extra latency. Applied in this order; each bullet uses the values produced by the ones before it:
  - month 0 -> 1; month >12 -> 12.
  - year 0 -> 1; year >9999 -> 9999.
  - day 0 -> 1; day > days_in_month(month, year) -> that length.
  - hour >23 -> 23; minute/second >59 -> 59.
  - week 0 or >7 -> 1.
  - Weekday is not recomputed from the date; the settings logic owns consistency.
- run=0: all outputs hold; count holds its value, so no partial second is lost or gained.
- No other state; no FSM beyond the divider/carry chain.

Decomposition:
- Package time_pkg holds:
  - Width constants: YEAR_W=16, MONTH_W=6, FIELD_W=11.
  - Limits: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, WEEK_MAX=7, YEAR_MAX=9999.
  - Function is_leap(year).
  - Function days_in_month(month, year).
- One sub-module: tick_divider (params CLK_HZ; ports clk, rst, en, clr, tick).
- Carry chain and load sanitising stay in time_keeper.

Test Plan (CLK_HZ=4):
- Reset, run=1, 4 cycles -> second=1, sec_tick pulses once; date 2000-01-01, week=6.
- Load 2023-12-31 23:59:59 week=7, wait one tick -> 2024-01-01 00:00:00, week=1.
- Load 2024-02-28 23:59:59 -> 2024-02-29. Load 2023-02-28 23:59:59 -> 2023-03-01. Load 1900-02-28 23:59:59 -> 1900-03-01. Load 2000-02-28 23:59:59 -> 2000-02-29.
- Load month=4 day=31 hour=30 week=0 -> day=30, hour=23, week=1. Load 9999-12-31 23:59:59 -> year=1, month=1, day=1.
- Load asserted in the same cycle as the tick -> loaded values appear, no increment, sec_tick=0. Next second arrives exactly 4 cycles later.
- run=0 for 10 cycles mid-second -> outputs frozen. After run=1, the remaining cycles of that second complete and then advance. rst asserted during a 23:59:59 rollover cycle -> reset values, no rollover.
